// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef logic mid_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [1:0]  ALIGN_MASK = 2'(WORD_BYTES - 1);

endpackage

// File: rtl/dmem_arbiter_if.sv
// One master channel of the arbiter: level-held request, one-cycle ack with error and read data.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, err, rdata);
  modport slave  (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/dmem_arbiter_rr.sv
// Combinational two-way pick; rr_i names the master that wins when both request.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  mid_t rr_i,
  output mid_t gnt_id_o,
  output logic gnt_vld_o
);
  assign gnt_vld_o = req0_i | req1_i;
  assign gnt_id_o  = (req0_i && req1_i) ? rr_i : req1_i;
endmodule

// File: rtl/dmem_arbiter.sv
// Two-master round-robin sequencer in front of Data_Memory: alignment/range check,
// fixed LATENCY access window, one-cycle ack and per-master read data.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_BYTES = 32,
  parameter int unsigned LATENCY   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              mem_MemWrite_o,
  output logic              mem_MemRead_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_write_data_o,
  input  logic [DATA_W-1:0] mem_data_i
);

  localparam int unsigned       CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LATENCY - 1);
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - WORD_BYTES);

  state_e            state_q, state_d;
  mid_t              rr_q, rr_d;
  mid_t              gnt_q, gnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  mid_t              pick_id;
  logic              pick_vld;
  logic              pick_we;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] pick_wdata;
  logic              pick_legal;

  rr_arbiter2 u_rr (
    .req0_i    (m0_req_i),
    .req1_i    (m1_req_i),
    .rr_i      (rr_q),
    .gnt_id_o  (pick_id),
    .gnt_vld_o (pick_vld)
  );

  always_comb begin
    pick_we    = pick_id ? m1_we_i    : m0_we_i;
    pick_addr  = pick_id ? m1_addr_i  : m0_addr_i;
    pick_wdata = pick_id ? m1_wdata_i : m0_wdata_i;
    pick_legal = ((pick_addr[1:0] & ALIGN_MASK) == 2'b00) && (pick_addr <= MAX_ADDR);
  end

  // Address/data registers load only on legal grants so the memory bus holds its last access.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d = pick_id;
          rr_d  = ~pick_id;
          err_d = ~pick_legal;
          if (pick_legal) begin
            we_d    = pick_we;
            addr_d  = pick_addr;
            wdata_d = pick_wdata;
            cnt_d   = CNT_LAST;
            state_d = ACCESS;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!we_q) begin
            if (gnt_q) rdata1_d = mem_data_i;
            else       rdata0_d = mem_data_i;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      gnt_q    <= 1'b0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign m0_ack_o   = (state_q == DONE) && (gnt_q == 1'b0);
  assign m1_ack_o   = (state_q == DONE) && (gnt_q == 1'b1);
  assign m0_err_o   = m0_ack_o && err_q;
  assign m1_err_o   = m1_ack_o && err_q;
  assign m0_rdata_o = rdata0_q;
  assign m1_rdata_o = rdata1_q;

  // Write strobe only in the final window cycle so the memory sees exactly one write edge.
  assign mem_MemRead_o    = (state_q == ACCESS) && !we_q;
  assign mem_MemWrite_o   = (state_q == ACCESS) && we_q && (cnt_q == '0);
  assign mem_addr_o       = addr_q;
  assign mem_write_data_o = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected responses queued at issue, checked on ack.
module tb_dmem_arbiter;

  localparam int unsigned MEMB = 32;
  localparam int          LAT  = 2;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          icyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  initial forever #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_bus ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_bus ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) n0_bus ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) n1_bus ();

  logic        mem_we, mem_re, n_mem_we, n_mem_re;
  logic [31:0] mem_addr, mem_wd, mem_rd, n_mem_addr, n_mem_wd, n_mem_rd;
  logic [31:0] memw  [0:7];
  logic [31:0] memw1 [0:7];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(MEMB), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_bus.req), .m0_we_i(m0_bus.we), .m0_addr_i(m0_bus.addr), .m0_wdata_i(m0_bus.wdata),
    .m0_ack_o(m0_bus.ack), .m0_err_o(m0_bus.err), .m0_rdata_o(m0_bus.rdata),
    .m1_req_i(m1_bus.req), .m1_we_i(m1_bus.we), .m1_addr_i(m1_bus.addr), .m1_wdata_i(m1_bus.wdata),
    .m1_ack_o(m1_bus.ack), .m1_err_o(m1_bus.err), .m1_rdata_o(m1_bus.rdata),
    .mem_MemWrite_o(mem_we), .mem_MemRead_o(mem_re), .mem_addr_o(mem_addr),
    .mem_write_data_o(mem_wd), .mem_data_i(mem_rd)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(MEMB), .LATENCY(1)) dut_l1 (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(n0_bus.req), .m0_we_i(n0_bus.we), .m0_addr_i(n0_bus.addr), .m0_wdata_i(n0_bus.wdata),
    .m0_ack_o(n0_bus.ack), .m0_err_o(n0_bus.err), .m0_rdata_o(n0_bus.rdata),
    .m1_req_i(n1_bus.req), .m1_we_i(n1_bus.we), .m1_addr_i(n1_bus.addr), .m1_wdata_i(n1_bus.wdata),
    .m1_ack_o(n1_bus.ack), .m1_err_o(n1_bus.err), .m1_rdata_o(n1_bus.rdata),
    .mem_MemWrite_o(n_mem_we), .mem_MemRead_o(n_mem_re), .mem_addr_o(n_mem_addr),
    .mem_write_data_o(n_mem_wd), .mem_data_i(n_mem_rd)
  );

  // Data_Memory stand-ins: combinational read, write on the clock edge.
  always_comb begin
    mem_rd   = (mem_addr <= 32'd28)   ? memw[mem_addr[4:2]]    : '0;
    n_mem_rd = (n_mem_addr <= 32'd28) ? memw1[n_mem_addr[4:2]] : '0;
  end

  initial forever begin
    @(posedge clk);
    if (mem_we && mem_addr <= 32'd28) memw[mem_addr[4:2]] = mem_wd;
    if (n_mem_we && n_mem_addr <= 32'd28) memw1[n_mem_addr[4:2]] = n_mem_wd;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int          n_pass = 0;
  int          n_total = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] refmem [0:7];
  logic [31:0] last_rd [2];
  int          last_served = 1;
  int          order_q[$];
  int          acks0 = 0;
  int          strobes = 0;
  int          wr_cnt = 0;
  int          wr_cyc = -1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, got, exp, $time);
  endtask

  task automatic sb_pop(input int k, input logic err, input logic [31:0] rd);
    exp_t e;
    int   sz;
    sz = (k == 0) ? q0.size() : q1.size();
    check($sformatf("m%0d_ack_expected", k), 32'(sz != 0), 32'd1);
    if (sz != 0) begin
      if (k == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      check($sformatf("m%0d_err", k), 32'(err), 32'(e.err));
      check($sformatf("m%0d_rdata", k), rd, e.rdata);
      if (e.lat >= 0) check($sformatf("m%0d_latency", k), 32'(cyc - e.icyc), 32'(e.lat));
    end
    order_q.push_back(k);
    last_served = k;
    if (k == 0) acks0++;
  endtask

  // Monitor: strobe accounting and scoreboard pops on every ack.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (mem_re || mem_we) strobes++;
      if (mem_we) begin
        wr_cnt++;
        wr_cyc = cyc;
      end
      if (m0_bus.ack || m1_bus.ack) check("single_ack", 32'(m0_bus.ack & m1_bus.ack), 32'd0);
      if (m0_bus.ack) sb_pop(0, m0_bus.err, m0_bus.rdata);
      if (m1_bus.ack) sb_pop(1, m1_bus.err, m1_bus.rdata);
    end
  end

  task automatic drive(input int k, input logic req, input logic we, input logic [31:0] a,
                       input logic [31:0] wd);
    if (k == 0) begin
      m0_bus.req = req; m0_bus.we = we; m0_bus.addr = a; m0_bus.wdata = wd;
    end else begin
      m1_bus.req = req; m1_bus.we = we; m1_bus.addr = a; m1_bus.wdata = wd;
    end
  endtask

  // Reference model: word-level memory plus legality rule; called at posedge+1.
  task automatic issue(input int k, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input bit chk_lat);
    exp_t e;
    bit   legal;
    bit   done;
    legal = (a % 4 == 0) && (longint'(a) + 3 < longint'(MEMB));
    if (legal && we)  refmem[a / 4] = wd;
    if (legal && !we) last_rd[k] = refmem[a / 4];
    e.err   = !legal;
    e.rdata = last_rd[k];
    e.lat   = chk_lat ? (legal ? LAT + 1 : 1) : -1;
    e.icyc  = cyc;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
    drive(k, 1'b1, we, a, wd);
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      done = (k == 0) ? m0_bus.ack : m1_bus.ack;
    end
    check($sformatf("m%0d_ack_in_time", k), 32'(done), 32'd1);
    @(posedge clk);
    #1;
    drive(k, 1'b0, we, a, wd);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    last_rd = '{default: '0};
    last_served = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_master(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      int          r;
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'(k * 16 + 4 * $urandom_range(0, 3) + $urandom_range(1, 3));
      else if (r == 1) a = 32'(32 + 4 * $urandom_range(0, 7));
      else if (r == 2) a = 32'hFFFF_FFFC;
      else             a = 32'(k * 16 + 4 * $urandom_range(0, 3));
      issue(k, 1'($urandom_range(0, 1)), a, $urandom, 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic l1_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input string tag, output logic [31:0] rd);
    int   c0;
    int   ack_c;
    logic e;
    c0 = cyc;
    n1_bus.req = 1'b1; n1_bus.we = we; n1_bus.addr = a; n1_bus.wdata = wd;
    ack_c = -1;
    e = 1'b1;
    rd = '0;
    for (int t = 0; t < 20 && ack_c < 0; t++) begin
      @(negedge clk);
      if (n1_bus.ack) begin
        ack_c = cyc;
        e     = n1_bus.err;
        rd    = n1_bus.rdata;
      end
    end
    check({tag, "_latency"}, 32'(ack_c - c0), 32'd2);
    check({tag, "_err"}, 32'(e), 32'd0);
    @(posedge clk);
    #1;
    n1_bus.req = 1'b0;
  endtask

  initial begin
    int          c0, w0, s0, a0, o0, exp_first;
    logic [31:0] v, old, rd;
    m0_bus.req = 0; m0_bus.we = 0; m0_bus.addr = 0; m0_bus.wdata = 0;
    m1_bus.req = 0; m1_bus.we = 0; m1_bus.addr = 0; m1_bus.wdata = 0;
    n0_bus.req = 0; n0_bus.we = 0; n0_bus.addr = 0; n0_bus.wdata = 0;
    n1_bus.req = 0; n1_bus.we = 0; n1_bus.addr = 0; n1_bus.wdata = 0;
    for (int i = 0; i < 8; i++) begin
      v = $urandom;
      memw[i]   = v;
      refmem[i] = v;
      memw1[i]  = $urandom;
    end
    last_rd = '{default: '0};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m0_ack",   32'(m0_bus.ack), 32'd0);
    check("rst_m1_ack",   32'(m1_bus.ack), 32'd0);
    check("rst_m0_err",   32'(m0_bus.err), 32'd0);
    check("rst_m0_rdata", m0_bus.rdata, 32'd0);
    check("rst_m1_rdata", m1_bus.rdata, 32'd0);
    check("rst_memwrite", 32'(mem_we), 32'd0);
    check("rst_memread",  32'(mem_re), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wd",   mem_wd, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Write then read back address 8 with timing of the write strobe.
    c0 = cyc;
    w0 = wr_cnt;
    issue(0, 1'b1, 32'd8, 32'hDEAD_BEEF, 1'b1);
    check("wr_strobe_cycle", 32'(wr_cyc - c0), 32'd2);
    check("wr_strobe_count", 32'(wr_cnt - w0), 32'd1);
    issue(0, 1'b0, 32'd8, 32'd0, 1'b1);

    // Simultaneous pairs: the master not served last wins.
    do_reset();
    o0 = order_q.size();
    exp_first = 1 - last_served;
    fork
      issue(0, 1'b0, 32'd0, 32'd0, 1'b0);
      issue(1, 1'b0, 32'd4, 32'd0, 1'b0);
    join
    check("pair1_first",  32'(order_q[o0]), 32'(exp_first));
    check("pair1_second", 32'(order_q[o0 + 1]), 32'(1 - exp_first));
    issue(0, 1'b1, 32'd12, $urandom, 1'b1);
    o0 = order_q.size();
    exp_first = 1 - last_served;
    fork
      issue(0, 1'b0, 32'd8, 32'd0, 1'b0);
      issue(1, 1'b0, 32'd12, 32'd0, 1'b0);
    join
    check("pair2_first",  32'(order_q[o0]), 32'(exp_first));
    check("pair2_second", 32'(order_q[o0 + 1]), 32'(1 - exp_first));

    // Misaligned and out-of-range requests: error ack, no memory strobe.
    s0 = strobes;
    issue(1, 1'b0, 32'd6, 32'd0, 1'b1);
    issue(1, 1'b0, 32'd32, 32'd0, 1'b1);
    check("err_no_strobe", 32'(strobes - s0), 32'd0);

    // m0 streams four transactions; m1 must get in after at most one of them.
    fork
      for (int i = 0; i < 4; i++) issue(0, 1'($urandom_range(0, 1)), 32'(4 * $urandom_range(0, 3)), $urandom, 1'b0);
      begin
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        a0 = acks0;
        issue(1, 1'b0, 32'd20, 32'd0, 1'b0);
        check("m1_fairness", 32'((acks0 - a0) <= 1), 32'd1);
      end
    join

    fork
      rand_master(0, 30);
      rand_master(1, 30);
    join

    // Reset during the first ACCESS cycle of a write to 12.
    old = refmem[3];
    c0 = cyc;
    drive(0, 1'b1, 1'b1, 32'd12, ~old);
    @(posedge clk);
    #2;
    rst = 1'b1;
    last_rd = '{default: '0};
    last_served = 1;
    #1;
    check("rstmid_m0_ack",   32'(m0_bus.ack), 32'd0);
    check("rstmid_memwrite", 32'(mem_we), 32'd0);
    check("rstmid_memread",  32'(mem_re), 32'd0);
    check("rstmid_mem_addr", mem_addr, 32'd0);
    check("rstmid_mem_wd",   mem_wd, 32'd0);
    check("rstmid_m0_rdata", m0_bus.rdata, 32'd0);
    check("rstmid_cycle",    32'(cyc - c0), 32'd1);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rstmid_word12_kept", memw[3], old);

    // LATENCY=1 instance: write and read back the top legal word.
    v = $urandom;
    l1_txn(1'b1, 32'd28, v, "l1_write", rd);
    l1_txn(1'b0, 32'd28, 32'd0, "l1_read", rd);
    check("l1_read_data", rd, v);

    check("m0_queue_drained", 32'(q0.size()), 32'd0);
    check("m1_queue_drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter/sequencer in front of the byte-addressed Data_Memory; m0 is the CPU MEM stage, m1 is the debug/DMA loader port.
- Accepts level-held req/ack transactions from each master, picks one with round-robin priority, and checks word alignment and range.
- Drives the memory's MemWrite/MemRead/addr/write_data for a fixed LATENCY window, returns read data and a one-cycle ack.
- The memory writes on the clock edge when MemWrite is high.

Parameters:
- ADDR_W, 32, address width of masters and memory.
- DATA_W, 32, data width (one word = 4 bytes, big-endian byte order as in Data_Memory).
- MEM_BYTES, 32, memory size in bytes; a legal address satisfies addr + 3 < MEM_BYTES.
- LATENCY, 2, number of ACCESS cycles per transaction (>= 1).

Ports:
- clk_i, in, 1, clock, all state updates on rising edge.
- rst_i, in, 1, asynchronous active-high reset.
- m0_req_i, in, 1, master 0 request; held with fields stable until ack.
- m0_we_i, in, 1, master 0: 1 = write, 0 = read.
- m0_addr_i, in, ADDR_W, master 0 byte address.
- m0_wdata_i, in, DATA_W, master 0 write data.
- m0_ack_o, out, 1, master 0 one-cycle completion pulse.
- m0_err_o, out, 1, master 0 error flag, valid with ack.
- m0_rdata_o, out, DATA_W, master 0 read data; held until the next read ack.
- m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_ack_o, m1_err_o, m1_rdata_o: same as m0, for master 1.
- mem_MemWrite_o, out, 1, to Data_Memory MemWrite_i.
- mem_MemRead_o, out, 1, to Data_Memory MemRead_i.
- mem_addr_o, out, ADDR_W, to Data_Memory addr_i.
- mem_write_data_o, out, DATA_W, to Data_Memory write_data_i.
- mem_data_i, in, DATA_W, from Data_Memory data_o (combinational read).

Behaviour:
- Reset (async, rst_i=1): state=IDLE, rr priority=m0, LATENCY counter=0, every output 0 (acks, errs, rdata, mem controls, mem_addr_o, mem_write_data_o). Memory contents untouched.
- FSM states: IDLE, ACCESS, DONE.
- IDLE arbitration:
  - No req: stay in IDLE.
  - One req: grant that master.
  - Both req: grant the master indicated by rr; after any grant to k, rr <= other master.
- On grant, latch we/addr/wdata and the grant id.
- Legality check: if addr[1:0] != 0 or addr > MEM_BYTES-4, go IDLE->DONE with err=1. No memory strobe is issued and rdata is unchanged.
- Legal grant: go to ACCESS with cnt=LATENCY-1.
- ACCESS:
  - mem_addr_o and mem_write_data_o show the latched values; mem_MemRead_o = ~we for the whole window.
  - mem_MemWrite_o is high only in the last ACCESS cycle (cnt==0), giving exactly one write edge.
  - For a read, capture mem_data_i into the granted rdata register at the edge ending the last ACCESS cycle.
  - cnt decrements each cycle; at cnt==0 go to DONE.
- DONE: ack_o=1 (plus err_o if set) to the granted master for exactly one cycle, then go to IDLE. The other master's ack/err stay 0.
- Latency: req seen in IDLE cycle 0 gives ack in cycle LATENCY+1 (legal) or cycle 1 (error). Back-to-back transactions cost LATENCY+2 cycles each.
- Master rule: drop req at the edge ending the ack cycle. If req is still high in the following IDLE, it is a new transaction.
- Requests arriving during ACCESS/DONE wait; no starvation, because rr alternates under continuous contention.
- Mem outputs: controls are 0 outside ACCESS; mem_addr_o and mem_write_data_o hold their last values.
- Reset mid-ACCESS before the last cycle: no write occurs and no ack is issued; the master must re-request.
- Masters' we/addr/wdata changes while not granted are ignored.

Decomposition:
- Package dmem_arb_pkg:
  - state enum {IDLE, ACCESS, DONE};
  - master-id type (1 bit);
  - WORD_BYTES=4 and the alignment mask constant.
- Sub-module rr_arbiter2: combinational 2-way pick from (req0, req1, rr) giving grant id and valid. The rr register stays in dmem_arbiter.

Test Plan:
- m0 write addr=8 data=0xDEADBEEF, LATENCY=2:
  - mem_MemWrite_o high only in cycle 2, m0_ack_o in cycle 3.
  - A subsequent m0 read of addr=8 returns 0xDEADBEEF with ack, err=0.
- Both req in the same cycle after reset (m0 read 0, m1 read 4):
  - m0 is acked first, then m1.
  - A second simultaneous pair is granted m1 first (rr alternation).
- m1 read addr=6 (misaligned), then addr=32 (out of range):
  - m1_ack_o and m1_err_o in cycle 1.
  - No mem_MemRead_o/mem_MemWrite_o pulse; m1_rdata_o unchanged.
- m0 holds req continuously for 4 transactions while m1 requests once: m1 is served after at most one m0 transaction.
- Assert rst_i during cycle 1 of an m0 write to addr=12 (LATENCY=2):
  - All outputs go to 0 immediately; no ack.
  - Memory word 12 keeps its old value.
- LATENCY=1 build, m1 write then read addr=28: ack in cycle 2 for each; read returns the written data; addr=28 is accepted as legal.
